// File: rtl/uart_frame_ctrl.sv
// Frame controller downstream of the UART receiver: SOF/ADDR/LEN/DATA/CHK
// framing, XOR checksum, burst commit to a register bank, frame statistics.
module uart_frame_ctrl #(
    parameter int          CLK_FREQ       = 50_000_000,
    parameter int          TIMEOUT_CYCLES = 50_000,
    parameter int          MAX_LEN        = 8,
    parameter logic [7:0]  SOF_BYTE       = 8'h7E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_LEN    = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    // A degenerate timeout falls back to 1 ms of clock cycles.
    localparam int TO_CYC = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES
                                                 : CLK_FREQ / 1000;
    localparam int GW = $clog2(TO_CYC + 1);
    localparam logic [GW-1:0] GAP_END = GW'(TO_CYC - 1);
    localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

    logic [2:0]    r_state;
    logic [7:0]    r_base;
    logic [7:0]    r_chk;
    logic [3:0]    r_len;
    logic [3:0]    r_idx;
    logic [7:0]    r_buf [16];
    logic [GW-1:0] r_gap;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic [15:0]   r_frame_cnt;
    logic [15:0]   r_err_cnt;

    logic          w_in_frame;
    logic          w_timeout;
    logic          w_len_bad;
    logic          w_chk_bad;
    logic          w_abort;
    logic [1:0]    w_code;
    logic          w_commit;

    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_LEN) ||
                        (r_state == S_DATA) || (r_state == S_CHK);
    assign w_timeout  = w_in_frame && !rx_valid && (r_gap == GAP_END);
    assign w_len_bad  = (r_state == S_LEN) && rx_valid &&
                        ((rx_data == 8'd0) || (rx_data > LEN_MAX));
    assign w_chk_bad  = (r_state == S_CHK) && rx_valid && (rx_data != r_chk);
    assign w_abort    = w_len_bad || w_chk_bad || w_timeout;
    assign w_commit   = (r_state == S_COMMIT);

    always_comb begin
        w_code = 2'd0;
        unique case (1'b1)
            w_len_bad: w_code = 2'd1;
            w_chk_bad: w_code = 2'd2;
            w_timeout: w_code = 2'd3;
            default:   w_code = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_chk       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_gap       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_in_frame && !rx_valid && !w_timeout) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            if (w_abort) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SOF_BYTE)) begin
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_base  <= rx_data;
                        r_chk   <= rx_data;
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (w_len_bad) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_len   <= rx_data[3:0];
                            r_chk   <= r_chk ^ rx_data;
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_buf[r_idx] <= rx_data;
                        r_chk        <= r_chk ^ rx_data;
                        r_idx        <= r_idx + 4'd1;
                        if ((r_idx + 4'd1) == r_len) begin
                            r_state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (rx_valid) begin
                        r_idx   <= '0;
                        r_state <= w_chk_bad ? S_IDLE : S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == (r_len - 4'd1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        if (r_frame_cnt != 16'hFFFF) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_timeout) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign wr_en       = w_commit;
    assign wr_addr     = w_commit ? (r_base + {4'd0, r_idx}) : 8'd0;
    assign wr_data     = w_commit ? r_buf[r_idx] : 8'd0;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_done;
    assign frame_err   = r_err;
    assign err_code    = r_err_code;
    assign frame_count = r_frame_cnt;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed vector table, exact
// timing sequences, and random frames against a frame-level model.
module tb_uart_frame_ctrl;

    localparam int TO = 64;
    localparam int ML = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    uart_frame_ctrl #(
        .CLK_FREQ(50_000_000),
        .TIMEOUT_CYCLES(TO),
        .MAX_LEN(ML),
        .SOF_BYTE(8'h7E)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .err_code(err_code),
        .frame_count(frame_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor: collects writes and pulses between compare points
    logic        mon_en = 1'b0;
    int          n_done = 0;
    int          n_err = 0;
    logic [15:0] wq[$];

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (wr_en) wq.push_back({wr_addr, wr_data});
            if (frame_done) n_done++;
            if (frame_err) n_err++;
        end
    end

    // Expected state
    logic [15:0] exp_wq[$];
    int          exp_done;
    int          exp_errp;
    int          exp_fc = 0;
    int          exp_ec = 0;
    int          exp_code = 0;

    typedef struct {
        int               n;
        logic [0:11][7:0] b;
        int               done;
        int               code;
        int               nwr;
        logic [15:0]      w0;
        logic [15:0]      w1;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        wq.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic compare_all(input string name);
        int m;
        chk({name, " done"}, n_done, exp_done);
        chk({name, " errp"}, n_err, exp_errp);
        chk({name, " nwr"}, wq.size(), exp_wq.size());
        m = (wq.size() < exp_wq.size()) ? wq.size() : exp_wq.size();
        for (int k = 0; k < m; k++) begin
            chk($sformatf("%s wr%0d", name, k), wq[k], exp_wq[k]);
        end
        chk({name, " code"}, err_code, exp_code);
        chk({name, " fcnt"}, frame_count, exp_fc);
        chk({name, " ecnt"}, err_count, exp_ec);
        chk({name, " busy"}, busy, 0);
    endtask

    task automatic check_zero(input string name);
        chk({name, " wr_en"}, wr_en, 0);
        chk({name, " wr_addr"}, wr_addr, 0);
        chk({name, " wr_data"}, wr_data, 0);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, frame_done, 0);
        chk({name, " err"}, frame_err, 0);
        chk({name, " code"}, err_code, 0);
        chk({name, " fcnt"}, frame_count, 0);
        chk({name, " ecnt"}, err_count, 0);
    endtask

    task automatic run_vec(input int i);
        clr();
        for (int j = 0; j < tv[i].n; j++) send_byte(tv[i].b[j]);
        idle(14);
        exp_wq.delete();
        if (tv[i].nwr > 0) exp_wq.push_back(tv[i].w0);
        if (tv[i].nwr > 1) exp_wq.push_back(tv[i].w1);
        exp_done = tv[i].done;
        exp_errp = (tv[i].code != 0) ? 1 : 0;
        if (tv[i].code != 0) begin
            exp_code = tv[i].code;
            exp_ec++;
        end
        if (tv[i].done != 0) exp_fc++;
        compare_all($sformatf("vec%0d", i));
    endtask

    initial begin
        logic [7:0] addr, len, chkb, x, g;
        logic [7:0] pl[8];
        logic [7:0] s[$];
        int kind, ng, k, wcnt;

        tv[0] = '{6, {8'h7E, 8'h10, 8'h02, 8'hA5, 8'h5A, 8'hED, 48'h0},
                  1, 0, 2, 16'h10A5, 16'h115A};
        tv[1] = '{6, {8'h7E, 8'h10, 8'h02, 8'hA5, 8'h5A, 8'hEE, 48'h0},
                  0, 2, 0, 16'h0, 16'h0};
        tv[2] = '{6, {8'h7E, 8'h10, 8'h02, 8'hA5, 8'h5A, 8'hED, 48'h0},
                  1, 0, 2, 16'h10A5, 16'h115A};
        tv[3] = '{3, {8'h7E, 8'h20, 8'h00, 72'h0},
                  0, 1, 0, 16'h0, 16'h0};
        tv[4] = '{3, {8'h7E, 8'h20, 8'h09, 72'h0},
                  0, 1, 0, 16'h0, 16'h0};
        tv[5] = '{8, {8'h00, 8'h33, 8'h7E, 8'hFF, 8'h02, 8'h11, 8'h22,
                      8'hCE, 32'h0},
                  1, 0, 2, 16'hFF11, 16'h0022};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Exact commit timing with back-to-back bytes
        send_byte(8'h7E); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hED);
        chk("t wr0 en", wr_en, 1);
        chk("t wr0 addr", wr_addr, 8'h10);
        chk("t wr0 data", wr_data, 8'hA5);
        chk("t wr0 done", frame_done, 0);
        idle(1);
        chk("t wr1 en", wr_en, 1);
        chk("t wr1 addr", wr_addr, 8'h11);
        chk("t wr1 data", wr_data, 8'h5A);
        idle(1);
        chk("t end en", wr_en, 0);
        chk("t end done", frame_done, 1);
        chk("t end busy", busy, 0);
        idle(1);
        chk("t after done", frame_done, 0);
        exp_fc++;
        chk("t fcnt", frame_count, exp_fc);

        // Exact bad-checksum timing
        send_byte(8'h7E); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hEE);
        chk("c err", frame_err, 1);
        chk("c busy", busy, 0);
        chk("c wr_en", wr_en, 0);
        chk("c code", err_code, 2);
        idle(1);
        chk("c err after", frame_err, 0);
        exp_ec++;
        exp_code = 2;
        chk("c ecnt", err_count, exp_ec);

        // Timeout fires after TO idle cycles following a byte
        send_byte(8'h7E); send_byte(8'h10);
        idle(TO - 1);
        chk("to pre err", frame_err, 0);
        chk("to pre busy", busy, 1);
        idle(1);
        chk("to err", frame_err, 1);
        chk("to busy", busy, 0);
        chk("to code", err_code, 3);
        exp_ec++;
        exp_code = 3;
        idle(2);
        chk("to ecnt", err_count, exp_ec);

        // Gaps of TO-2 idle cycles never time out
        clr();
        send_byte(8'h7E);
        idle(TO - 2); send_byte(8'h10);
        idle(TO - 2); send_byte(8'h02);
        idle(TO - 2); send_byte(8'hA5);
        idle(TO - 2); send_byte(8'h5A);
        idle(TO - 2); send_byte(8'hED);
        idle(6);
        exp_wq.delete();
        exp_wq.push_back(16'h10A5);
        exp_wq.push_back(16'h115A);
        exp_done = 1;
        exp_errp = 0;
        exp_fc++;
        compare_all("gap");

        // Random frames against the frame-level model
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 5);
            addr = 8'($urandom);
            if (kind == 4)
                len = ($urandom_range(0, 1) == 0) ? 8'd0
                      : 8'($urandom_range(ML + 1, 255));
            else
                len = 8'($urandom_range(1, ML));
            for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
            x = addr ^ len;
            if (kind != 4)
                for (int i = 0; i < int'(len); i++) x = x ^ pl[i];
            chkb = (kind == 3) ? (x ^ 8'($urandom_range(1, 255))) : x;

            s.delete();
            ng = $urandom_range(0, 2);
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom);
                if (g == 8'h7E) g = 8'h00;
                s.push_back(g);
            end
            s.push_back(8'h7E);
            s.push_back(addr);
            s.push_back(len);
            if (kind != 4) begin
                for (int i = 0; i < int'(len); i++) s.push_back(pl[i]);
                s.push_back(chkb);
            end
            if (kind == 5) begin
                k = $urandom_range(0, int'(len) + 2);
                while (s.size() > ng + 1 + k) void'(s.pop_back());
            end

            exp_wq.delete();
            exp_done = 0;
            exp_errp = 0;
            if (kind == 5) begin
                exp_errp = 1; exp_code = 3;
            end else if (len == 0 || len > ML) begin
                exp_errp = 1; exp_code = 1;
            end else if (chkb != x) begin
                exp_errp = 1; exp_code = 2;
            end else begin
                exp_done = 1;
                for (int i = 0; i < int'(len); i++)
                    exp_wq.push_back({8'(addr + 8'(i)), pl[i]});
            end
            if (exp_errp != 0) exp_ec++;
            if (exp_done != 0) exp_fc++;

            clr();
            foreach (s[i]) begin
                send_byte(s[i]);
                idle($urandom_range(0, 3));
            end
            idle((kind == 5) ? TO + 4 : 14);
            compare_all($sformatf("rnd%0d", f));
        end

        // Reset during the first write of an 8-byte frame
        send_byte(8'h7E); send_byte(8'h40); send_byte(8'h08);
        x = 8'h40 ^ 8'h08;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1));
            x = x ^ 8'(i + 1);
        end
        send_byte(x);
        chk("rst first wr", wr_en, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        idle(1);
        check_zero("rst mid");
        rst_n = 1'b1;
        wcnt = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (wr_en) wcnt++;
        end
        chk("rst no writes", wcnt, 0);
        exp_fc = 0;
        exp_ec = 0;
        exp_code = 0;
        mon_en = 1'b1;
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
